clkdiv_ctrl: RTL and testbench

Programmable, glitch-free clock-divider controller. It divides `clk` by a run-time ratio N and starts and stops the divided output only on period boundaries. Ratio changes arrive over a req/ack handshake and are applied only at the end of the current output period. It sits between the configuration register block and the fixed divide-by-2/4 dividers, replacing hard-wired ratios for peripherals that need software-selectable clocks.

---
 rtl/clkdiv_ctrl.sv | 147 ++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: glitch-free programmable clock divider with req/ack ratio updates.
// Odd ratios are accepted only when CLKDIV_ODD_EN is defined.
module clkdiv_ctrl #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             out_clk,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DEF_R = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MIN_R = DIV_W'(2);

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] ratio;
    logic [DIV_W-1:0] ratio_n;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] pval;
    logic [DIV_W-1:0] pval_n;
    logic [DIV_W-1:0] low_len;
    logic             pend;
    logic             pend_n;
    logic             ack_n;
    logic             err_n;
    logic             boundary;
    logic             legal;
    logic             run_n;
    logic             out_n;
    logic             tick_n;

    // Last cycle of an output period: the only point where a running
    // ratio may change or the output may go idle.
    assign boundary = (state != IDLE) && (cnt == ratio - 1'b1);

`ifdef CLKDIV_ODD_EN
    assign legal = (pval >= MIN_R);
`else
    assign legal = (pval >= MIN_R) && !pval[0];
`endif

    // Period counter and run/stop sequencing.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                cnt_n = boundary ? '0 : cnt + 1'b1;
                if (!en) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                cnt_n = boundary ? '0 : cnt + 1'b1;
                if (en) begin
                    state_n = RUN;
                end else if (boundary) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // One-deep pending ratio: capture, then retire with error or apply.
    always_comb begin
        ratio_n = ratio;
        pend_n  = pend;
        pval_n  = pval;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        if (pend) begin
            if (!legal) begin
                ack_n  = 1'b1;
                err_n  = 1'b1;
                pend_n = 1'b0;
            end else if (state == IDLE || boundary) begin
                ratio_n = pval;
                ack_n   = 1'b1;
                pend_n  = 1'b0;
            end
        end else if (div_req && !div_ack) begin
            pend_n = 1'b1;
            pval_n = div_val;
        end
    end

    // Outputs are derived from next-state values so they register cleanly.
    always_comb begin
        run_n   = (state_n != IDLE);
        low_len = ratio_n - (ratio_n >> 1);
        out_n   = run_n && (cnt_n >= low_len);
        tick_n  = run_n && (cnt_n == '0);
    end

    // State, ratio, pending buffer and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ratio   <= DEF_R;
            cnt     <= '0;
            pend    <= 1'b0;
            pval    <= '0;
            div_ack <= 1'b0;
            div_err <= 1'b0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            ratio   <= ratio_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            pval    <= pval_n;
            div_ack <= ack_n;
            div_err <= err_n;
            out_clk <= out_n;
            tick    <= tick_n;
            busy    <= run_n;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: randomized scoreboard bench for clkdiv_ctrl.
// Reference model works per output period; build with CLKDIV_ODD_EN to match the DUT.
module tb_clkdiv_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       div_req;
    logic [7:0] div_val;
    logic       div_ack;
    logic       div_err;
    logic       out_clk;
    logic       tick;
    logic       busy;

    int checks;
    int errors;
    int cyc;

    clkdiv_ctrl #(.DIV_W(8), .DEF_DIV(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_err (div_err),
        .out_clk (out_clk),
        .tick    (tick),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit legal(int unsigned v);
`ifdef CLKDIV_ODD_EN
        return v >= 2;
`else
        return (v >= 2) && (v % 2 == 0);
`endif
    endfunction

    // Reference model: an output period of n cycles is n-n/2 low then n/2 high.
    // A period is followed by another unless en was low on its last two edges.
    int unsigned m_ratio;
    int unsigned m_n;
    int unsigned m_pos;
    bit          m_run;
    bit          m_pend;
    bit          m_ackp;
    bit          m_enp;
    int unsigned m_pval;
    logic [4:0]  exp_q[$];

    always @(posedge clk or negedge rstn) begin
        bit at_end;
        bit a;
        bit e;
        if (!rstn) begin
            m_ratio = 4;
            m_n     = 4;
            m_pos   = 0;
            m_run   = 0;
            m_pend  = 0;
            m_ackp  = 0;
            m_enp   = 0;
            m_pval  = 0;
            exp_q.delete();
        end else begin
            at_end = m_run && (m_pos == m_n - 1);
            a = 0;
            e = 0;
            if (m_pend) begin
                if (!legal(m_pval)) begin
                    a = 1;
                    e = 1;
                end else if (!m_run || at_end) begin
                    m_ratio = m_pval;
                    a = 1;
                end
                if (a) m_pend = 0;
            end else if (div_req && !m_ackp) begin
                m_pend = 1;
                m_pval = div_val;
            end
            if (!m_run) begin
                if (en) begin
                    m_run = 1;
                    m_pos = 0;
                    m_n   = m_ratio;
                end
            end else if (at_end) begin
                if (!m_enp && !en) begin
                    m_run = 0;
                end else begin
                    m_pos = 0;
                    m_n   = m_ratio;
                end
            end else begin
                m_pos = m_pos + 1;
            end
            m_enp  = en;
            m_ackp = a;
            exp_q.push_back({m_run && (m_pos >= m_n - m_n / 2),
                             m_run && (m_pos == 0), m_run, a, e});
        end
    end

    // Monitor: one expected record per clk cycle, compared mid-cycle.
    logic [4:0] exp_v;
    logic [4:0] got_v;
    always @(negedge clk) begin
        if (rstn && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {out_clk, tick, busy, div_ack, div_err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cyc %0d {out,tick,busy,ack,err} got %b exp %b",
                         cyc, got_v, exp_v);
            end
        end
    end

    function automatic logic [7:0] pick();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r <= 6) return 8'($urandom_range(0, 12));
        if (r == 9) return 8'd2;
        return 8'($urandom_range(0, 255));
    endfunction

    bit drop;

    task automatic req_step(input bit allow_new);
        if (div_req) begin
            if (drop) begin
                div_req = 1'b0;
                drop    = 1'b0;
            end else if (div_ack) begin
                drop = 1'b1;
            end
        end else if (allow_new && $urandom_range(0, 5) == 0) begin
            div_val = pick();
            div_req = 1'b1;
        end
    endtask

    initial begin
        bit found;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        drop    = 0;
        rstn    = 1'b0;
        en      = 1'b0;
        div_req = 1'b0;
        div_val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_clk, tick, busy, div_ack, div_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got %b exp 00000",
                     {out_clk, tick, busy, div_ack, div_err});
        end
        #2 rstn = 1'b1;

        // Default ratio 4 from reset: 0,0,1,1 repeating.
        en = 1'b1;
        repeat (20) @(negedge clk);

        // Randomized enable and ratio traffic.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            req_step(1'b1);
            if ($urandom_range(0, 9) == 0) en = !en;
        end

        // Let any handshake in flight complete.
        for (int i = 0; i < 600 && div_req; i++) begin
            @(negedge clk);
            req_step(1'b0);
        end

        // Reset in the high phase while a legal request is pending.
        en      = 1'b1;
        div_val = 8'd12;
        div_req = 1'b1;
        found   = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (m_pend && m_run && (m_pos >= m_n - m_n / 2)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_setup got no pending high phase exp one");
        end
        #2;
        rstn    = 1'b0;
        div_req = 1'b0;
        en      = 1'b0;
        #1;
        checks++;
        if ({out_clk, tick, busy, div_ack, div_err} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got %b exp 00000",
                     {out_clk, tick, busy, div_ack, div_err});
        end
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        en = 1'b1;
        repeat (40) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
